// File: rtl/wfaa_job_sequencer.sv
//------------------------------------------------------------------------------
// wfaa_job_sequencer
//
// Runs one TALCO_WFAA alignment core through complete jobs. A job descriptor is
// accepted in IDLE. The reference tile and then the query tile are streamed
// from the shared sequence memory into the core's tile buffers. The sequencer
// then pulses start, waits for the core's stop, and reports completion through
// the done handshake.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   job_valid / job_ready       job descriptor handshake (ready only in IDLE)
//   job_id                      job tag, echoed on done_id
//   job_ref_base/job_query_base sequence memory start addresses
//   job_ref_len/job_query_len   requested lengths (clamped to MAX_TILE_SIZE)
//   mem_rd_en/mem_rd_addr       sequence memory read, data returns 1 cycle later
//   mem_rd_data                 sequence memory read data
//   loadData                    any tile buffer write this cycle
//   refWe/refAdr/refData        reference tile buffer write port
//   queryWe/queryAdr/queryData  query tile buffer write port
//   refLen/queryLen             clamped lengths of the current job
//   start                       one-cycle launch pulse to the core
//   stop                        core finished (only observed in RUN)
//   done_valid/done_ready       completion handshake
//   done_id/done_clamped        tag of finished job, a length was clamped
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module wfaa_job_sequencer #(
   parameter int DATA_WIDTH        = 8,
   parameter int LOG_MAX_TILE_SIZE = 10,
   parameter int MAX_TILE_SIZE     = 1024,
   parameter int REF_LEN_WIDTH     = 14,
   parameter int QUERY_LEN_WIDTH   = 14,
   parameter int SEQ_ADDR_WIDTH    = 16,
   parameter int ID_WIDTH          = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   // job descriptor
   input  logic                         job_valid,
   output logic                         job_ready,
   input  logic [ID_WIDTH-1:0]          job_id,
   input  logic [SEQ_ADDR_WIDTH-1:0]    job_ref_base,
   input  logic [SEQ_ADDR_WIDTH-1:0]    job_query_base,
   input  logic [REF_LEN_WIDTH-1:0]     job_ref_len,
   input  logic [QUERY_LEN_WIDTH-1:0]   job_query_len,
   // sequence memory
   output logic                         mem_rd_en,
   output logic [SEQ_ADDR_WIDTH-1:0]    mem_rd_addr,
   input  logic [DATA_WIDTH-1:0]        mem_rd_data,
   // core tile buffers
   output logic                         loadData,
   output logic                         refWe,
   output logic                         queryWe,
   output logic [LOG_MAX_TILE_SIZE-1:0] refAdr,
   output logic [LOG_MAX_TILE_SIZE-1:0] queryAdr,
   output logic [DATA_WIDTH-1:0]        refData,
   output logic [DATA_WIDTH-1:0]        queryData,
   output logic [REF_LEN_WIDTH-1:0]     refLen,
   output logic [QUERY_LEN_WIDTH-1:0]   queryLen,
   // core control
   output logic                         start,
   input  logic                         stop,
   // completion
   output logic                         done_valid,
   input  logic                         done_ready,
   output logic [ID_WIDTH-1:0]          done_id,
   output logic                         done_clamped
);

   localparam logic [REF_LEN_WIDTH-1:0]   REF_MAX = REF_LEN_WIDTH'(MAX_TILE_SIZE);
   localparam logic [QUERY_LEN_WIDTH-1:0] QRY_MAX = QUERY_LEN_WIDTH'(MAX_TILE_SIZE);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_REF,
      LOAD_QRY,
      DRAIN,
      START,
      RUN,
      DONE
   } state_t;

   state_t state;

   // Job fields that only matter after accept; no reset needed.
   logic [ID_WIDTH-1:0]       id_q;
   logic [SEQ_ADDR_WIDTH-1:0] qry_base_q;
   logic                      clamp_q;

   // Read-issue stage: tile index and stream of the read on mem_rd_en.
   logic [LOG_MAX_TILE_SIZE-1:0] rd_idx_p0;
   logic                         rd_qry_p0;

   logic [REF_LEN_WIDTH-1:0]   job_r;
   logic [QUERY_LEN_WIDTH-1:0] job_q;
   logic                       job_clamp;
   logic                       job_accept;
   logic                       last_ref;
   logic                       last_qry;

   function automatic logic [REF_LEN_WIDTH-1:0] sat_ref_len(
      input logic [REF_LEN_WIDTH-1:0] len
   );
      if (len > REF_MAX) return REF_MAX;
      return len;
   endfunction

   function automatic logic [QUERY_LEN_WIDTH-1:0] sat_qry_len(
      input logic [QUERY_LEN_WIDTH-1:0] len
   );
      if (len > QRY_MAX) return QRY_MAX;
      return len;
   endfunction

   assign job_r      = sat_ref_len(job_ref_len);
   assign job_q      = sat_qry_len(job_query_len);
   assign job_clamp  = (job_ref_len > REF_MAX) | (job_query_len > QRY_MAX);
   assign job_accept = job_valid & job_ready;

   // The read on the bus this cycle is the last of its stream.
   assign last_ref = (REF_LEN_WIDTH'(rd_idx_p0) == refLen - REF_LEN_WIDTH'(1));
   assign last_qry = (QUERY_LEN_WIDTH'(rd_idx_p0) == queryLen - QUERY_LEN_WIDTH'(1));

   // Write stage data is the memory return itself; the write enables and
   // addresses are the read-issue stage delayed by one cycle.
   assign refData   = mem_rd_data;
   assign queryData = mem_rd_data;
   assign loadData  = refWe | queryWe;

   always_ff @(posedge clk) begin
      if (job_accept) begin
         id_q       <= job_id;
         qry_base_q <= job_query_base;
         clamp_q    <= job_clamp;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         job_ready    <= 1'b1;
         mem_rd_en    <= 1'b0;
         mem_rd_addr  <= '0;
         rd_idx_p0    <= '0;
         rd_qry_p0    <= 1'b0;
         refWe        <= 1'b0;
         queryWe      <= 1'b0;
         refAdr       <= '0;
         queryAdr     <= '0;
         refLen       <= '0;
         queryLen     <= '0;
         start        <= 1'b0;
         done_valid   <= 1'b0;
         done_id      <= '0;
         done_clamped <= 1'b0;
      end else begin
         // ---- stage p0 -> p1: read issued last cycle becomes a tile write ----
         refWe   <= mem_rd_en & ~rd_qry_p0;
         queryWe <= mem_rd_en & rd_qry_p0;
         if (mem_rd_en & ~rd_qry_p0) refAdr   <= rd_idx_p0;
         if (mem_rd_en & rd_qry_p0)  queryAdr <= rd_idx_p0;

         // ---- read issue (p0) and sequencing ----
         start     <= 1'b0;
         mem_rd_en <= 1'b0;

         case (state)
            IDLE: begin
               if (job_accept) begin
                  job_ready <= 1'b0;
                  refLen    <= job_r;
                  queryLen  <= job_q;
                  rd_idx_p0 <= '0;
                  if (job_r != '0) begin
                     state       <= LOAD_REF;
                     mem_rd_en   <= 1'b1;
                     mem_rd_addr <= job_ref_base;
                     rd_qry_p0   <= 1'b0;
                  end else if (job_q != '0) begin
                     state       <= LOAD_QRY;
                     mem_rd_en   <= 1'b1;
                     mem_rd_addr <= job_query_base;
                     rd_qry_p0   <= 1'b1;
                  end else begin
                     state <= START;
                     start <= 1'b1;
                  end
               end
            end

            LOAD_REF: begin
               if (last_ref) begin
                  // Query stream follows with no bubble.
                  if (queryLen != '0) begin
                     state       <= LOAD_QRY;
                     mem_rd_en   <= 1'b1;
                     mem_rd_addr <= qry_base_q;
                     rd_idx_p0   <= '0;
                     rd_qry_p0   <= 1'b1;
                  end else begin
                     state <= DRAIN;
                  end
               end else begin
                  mem_rd_en   <= 1'b1;
                  mem_rd_addr <= mem_rd_addr + SEQ_ADDR_WIDTH'(1);
                  rd_idx_p0   <= rd_idx_p0 + LOG_MAX_TILE_SIZE'(1);
               end
            end

            LOAD_QRY: begin
               if (last_qry) begin
                  state <= DRAIN;
               end else begin
                  mem_rd_en   <= 1'b1;
                  mem_rd_addr <= mem_rd_addr + SEQ_ADDR_WIDTH'(1);
                  rd_idx_p0   <= rd_idx_p0 + LOG_MAX_TILE_SIZE'(1);
               end
            end

            // Final tile write lands while in DRAIN.
            DRAIN: begin
               state <= START;
               start <= 1'b1;
            end

            START: begin
               state <= RUN;
            end

            RUN: begin
               if (stop) begin
                  state        <= DONE;
                  done_valid   <= 1'b1;
                  done_id      <= id_q;
                  done_clamped <= clamp_q;
               end
            end

            DONE: begin
               if (done_ready) begin
                  state      <= IDLE;
                  done_valid <= 1'b0;
                  job_ready  <= 1'b1;
               end
            end

            default: begin
               state     <= IDLE;
               job_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wfaa_job_sequencer.sv
`timescale 1ns/1ps
module tb_wfaa_job_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        job_valid;
   logic        job_ready;
   logic [3:0]  job_id;
   logic [15:0] job_ref_base;
   logic [15:0] job_query_base;
   logic [13:0] job_ref_len;
   logic [13:0] job_query_len;
   logic        mem_rd_en;
   logic [15:0] mem_rd_addr;
   logic [7:0]  mem_rd_data = 8'h00;
   logic        loadData;
   logic        refWe;
   logic        queryWe;
   logic [9:0]  refAdr;
   logic [9:0]  queryAdr;
   logic [7:0]  refData;
   logic [7:0]  queryData;
   logic [13:0] refLen;
   logic [13:0] queryLen;
   logic        start;
   logic        stop;
   logic        done_valid;
   logic        done_ready;
   logic [3:0]  done_id;
   logic        done_clamped;

   int checks = 0;
   int errors = 0;
   bit mem_low = 1'b1;

   wfaa_job_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .job_valid      (job_valid),
      .job_ready      (job_ready),
      .job_id         (job_id),
      .job_ref_base   (job_ref_base),
      .job_query_base (job_query_base),
      .job_ref_len    (job_ref_len),
      .job_query_len  (job_query_len),
      .mem_rd_en      (mem_rd_en),
      .mem_rd_addr    (mem_rd_addr),
      .mem_rd_data    (mem_rd_data),
      .loadData       (loadData),
      .refWe          (refWe),
      .queryWe        (queryWe),
      .refAdr         (refAdr),
      .queryAdr       (queryAdr),
      .refData        (refData),
      .queryData      (queryData),
      .refLen         (refLen),
      .queryLen       (queryLen),
      .start          (start),
      .stop           (stop),
      .done_valid     (done_valid),
      .done_ready     (done_ready),
      .done_id        (done_id),
      .done_clamped   (done_clamped)
   );

   always #5 clk = ~clk;

   // Sequence memory contents: either the address low byte or a scrambled hash.
   function automatic logic [7:0] memf(input logic [15:0] a);
      if (mem_low) return a[7:0];
      return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
   endfunction

   // Memory with one cycle of read latency.
   always @(posedge clk) mem_rd_data <= mem_rd_en ? memf(mem_rd_addr) : 8'h00;

   initial begin
      #900000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // Runs one job from IDLE through the done handshake. Entered and left at a
   // negedge with the DUT in IDLE. Cycle k is k cycles after the accept cycle.
   task automatic run_job(input logic [3:0] id, input logic [15:0] rb, input logic [13:0] rl,
                          input logic [15:0] qb, input logic [13:0] ql,
                          input int stop_dly, input int rdy_dly, input bit noise,
                          input string name);
      int R, Q, k_start;
      bit clamped, exp_rd, exp_rw, exp_qw;
      logic [15:0] ea;
      R = (rl > 14'd1024) ? 1024 : int'(rl);
      Q = (ql > 14'd1024) ? 1024 : int'(ql);
      clamped = (rl > 14'd1024) || (ql > 14'd1024);
      k_start = (R + Q == 0) ? 1 : R + Q + 2;

      checks++;
      if (job_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s accept_ready got %b exp 1", name, job_ready);
      end
      job_valid = 1'b1; job_id = id; job_ref_base = rb; job_ref_len = rl;
      job_query_base = qb; job_query_len = ql;
      @(posedge clk);

      for (int k = 1; k <= k_start; k++) begin
         @(negedge clk);
         exp_rd = (k <= R + Q);
         ea = (k <= R) ? rb + 16'(k - 1) : qb + 16'(k - 1 - R);
         checks++;
         if (mem_rd_en !== exp_rd || (exp_rd && mem_rd_addr !== ea)) begin
            errors++;
            $display("FAIL %s read k=%0d got en=%b addr=%h exp en=%b addr=%h",
                     name, k, mem_rd_en, mem_rd_addr, exp_rd, ea);
         end
         exp_rw = (k >= 2) && (k <= R + 1);
         exp_qw = (k >= R + 2) && (k <= R + Q + 1);
         checks++;
         if (refWe !== exp_rw || queryWe !== exp_qw || loadData !== (exp_rw | exp_qw)) begin
            errors++;
            $display("FAIL %s we k=%0d got ref=%b qry=%b load=%b exp ref=%b qry=%b",
                     name, k, refWe, queryWe, loadData, exp_rw, exp_qw);
         end
         if (exp_rw) begin
            checks++;
            if (refAdr !== 10'(k - 2) || refData !== memf(rb + 16'(k - 2))) begin
               errors++;
               $display("FAIL %s ref_write k=%0d got adr=%0d data=%h exp adr=%0d data=%h",
                        name, k, refAdr, refData, k - 2, memf(rb + 16'(k - 2)));
            end
         end
         if (exp_qw) begin
            checks++;
            if (queryAdr !== 10'(k - 2 - R) || queryData !== memf(qb + 16'(k - 2 - R))) begin
               errors++;
               $display("FAIL %s qry_write k=%0d got adr=%0d data=%h exp adr=%0d data=%h",
                        name, k, queryAdr, queryData, k - 2 - R, memf(qb + 16'(k - 2 - R)));
            end
         end
         checks++;
         if (start !== (k == k_start)) begin
            errors++;
            $display("FAIL %s start k=%0d got %b exp %b", name, k, start, k == k_start);
         end
         checks++;
         if (job_ready !== 1'b0 || done_valid !== 1'b0 || refLen !== 14'(R) || queryLen !== 14'(Q)) begin
            errors++;
            $display("FAIL %s busy k=%0d got ready=%b dv=%b rlen=%0d qlen=%0d exp 0 0 %0d %0d",
                     name, k, job_ready, done_valid, refLen, queryLen, R, Q);
         end
         // Extra job offers and early stop must both be ignored while busy.
         job_valid = noise;
         if (noise) begin
            job_id = 4'($urandom); job_ref_base = 16'($urandom); job_ref_len = 14'($urandom);
            job_query_base = 16'($urandom); job_query_len = 14'($urandom);
         end
         stop = (k < k_start) ? (noise & 1'($urandom)) : 1'b0;
      end

      for (int i = 0; i <= stop_dly; i++) begin
         @(negedge clk);
         checks++;
         if (done_valid !== 1'b0 || start !== 1'b0 || job_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s run i=%0d got dv=%b start=%b ready=%b exp 0 0 0",
                     name, i, done_valid, start, job_ready);
         end
         stop = (i == stop_dly);
      end

      for (int i = 0; i <= rdy_dly; i++) begin
         @(negedge clk);
         stop = 1'b0;
         checks++;
         if (done_valid !== 1'b1 || done_id !== id || done_clamped !== clamped || job_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s done i=%0d got dv=%b id=%h clamp=%b ready=%b exp 1 %h %b 0",
                     name, i, done_valid, done_id, done_clamped, job_ready, id, clamped);
         end
         done_ready = (i == rdy_dly);
         job_valid  = (i == rdy_dly) ? 1'b0 : noise;
      end

      @(negedge clk);
      done_ready = 1'b0;
      checks++;
      if (done_valid !== 1'b0 || job_ready !== 1'b1 || start !== 1'b0 || mem_rd_en !== 1'b0) begin
         errors++;
         $display("FAIL %s idle got dv=%b ready=%b start=%b rd=%b exp 0 1 0 0",
                  name, done_valid, job_ready, start, mem_rd_en);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; job_valid = 1'b0; job_id = '0; job_ref_base = '0; job_query_base = '0;
      job_ref_len = '0; job_query_len = '0; stop = 1'b0; done_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({mem_rd_en, loadData, refWe, queryWe, start, done_valid, done_clamped} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b exp 0000000",
                  {mem_rd_en, loadData, refWe, queryWe, start, done_valid, done_clamped});
      end
      checks++;
      if (job_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %b exp 1", job_ready);
      end
      checks++;
      if (refAdr !== '0 || queryAdr !== '0 || mem_rd_addr !== '0) begin
         errors++;
         $display("FAIL reset_addr got %h %h %h exp 0 0 0", refAdr, queryAdr, mem_rd_addr);
      end
      checks++;
      if (refLen !== '0 || queryLen !== '0 || done_id !== '0) begin
         errors++;
         $display("FAIL reset_len got %0d %0d %h exp 0 0 0", refLen, queryLen, done_id);
      end
   endtask

   task automatic test_basic();
      mem_low = 1'b1;
      run_job(4'd3, 16'h0100, 14'd4, 16'h0200, 14'd3, 10, 0, 1'b0, "basic");
   endtask

   task automatic test_zero_len();
      run_job(4'd7, 16'h1234, 14'd0, 16'h4321, 14'd0, 2, 1, 1'b0, "zero_len");
      run_job(4'd8, 16'h1234, 14'd0, 16'h0F00, 14'd5, 1, 0, 1'b0, "ref_zero");
   endtask

   task automatic test_clamp();
      mem_low = 1'b0;
      run_job(4'd9, 16'h2000, 14'd2000, 16'h3000, 14'd1, 0, 0, 1'b0, "clamp");
   endtask

   task automatic test_wrap();
      mem_low = 1'b0;
      run_job(4'd5, 16'hFFFE, 14'd4, 16'hFFFF, 14'd3, 0, 0, 1'b0, "wrap");
   endtask

   task automatic test_back_to_back();
      run_job(4'd11, 16'h0040, 14'd3, 16'h0080, 14'd2, 1, 5, 1'b1, "backpressure");
      run_job(4'd12, 16'h0500, 14'd2, 16'h0600, 14'd2, 0, 0, 1'b0, "back_to_back");
   endtask

   task automatic test_reset_mid();
      job_valid = 1'b1; job_id = 4'd6; job_ref_base = 16'h0700; job_ref_len = 14'd5;
      job_query_base = 16'h0800; job_query_len = 14'd6;
      @(posedge clk);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         job_valid = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({mem_rd_en, loadData, refWe, queryWe, start, done_valid, done_clamped} !== 7'b0
          || job_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_ctrl got %b ready=%b exp 0000000 ready=1",
                  {mem_rd_en, loadData, refWe, queryWe, start, done_valid, done_clamped}, job_ready);
      end
      checks++;
      if (refLen !== '0 || queryLen !== '0 || done_id !== '0 || refAdr !== '0 || queryAdr !== '0) begin
         errors++;
         $display("FAIL reset_mid_data got rlen=%0d qlen=%0d id=%h radr=%0d qadr=%0d exp all 0",
                  refLen, queryLen, done_id, refAdr, queryAdr);
      end
      stop = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (done_valid !== 1'b0 || job_ready !== 1'b1 || mem_rd_en !== 1'b0 || loadData !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_quiet i=%0d got dv=%b ready=%b rd=%b load=%b exp 0 1 0 0",
                     i, done_valid, job_ready, mem_rd_en, loadData);
         end
      end
      stop = 1'b0;
      run_job(4'd13, 16'h0900, 14'd3, 16'h0A00, 14'd4, 2, 1, 1'b0, "after_reset");
   endtask

   task automatic test_random();
      logic [13:0] rl, ql;
      for (int j = 0; j < 20; j++) begin
         mem_low = 1'($urandom);
         rl = ($urandom_range(0, 11) == 0) ? 14'($urandom_range(1025, 16383)) : 14'($urandom_range(0, 40));
         ql = ($urandom_range(0, 11) == 0) ? 14'($urandom_range(1025, 16383)) : 14'($urandom_range(0, 40));
         run_job(4'($urandom), 16'($urandom), rl, 16'($urandom), ql,
                 $urandom_range(0, 5), $urandom_range(0, 3), 1'($urandom), "random");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_len();
      test_clamp();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
